// File: rtl/spu_fwd_pipeline_pkg.sv
// Purpose: shared constants, shadow-entry layout and sizing helper for the SPU forwarding pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spu_fwd_pipeline_pkg;

  localparam int DEF_NUM_PIPES = 2;
  localparam int DEF_DEPTH     = 7;
  localparam int DEF_NUM_RD    = 3;
  localparam int DEF_DATA_WD   = 128;
  localparam int DEF_ADDR_WD   = 7;

  // One in-flight shadow entry at the default widths.
  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic [DEF_ADDR_WD-1:0] addr;
    logic [DEF_DATA_WD-1:0] data;
  } fw_entry_t;

  // Stage numbers run 1..depth, so they need room for the value depth itself.
  function automatic int stage_wd(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spu_fwd_lane.sv
// Purpose: one issue pipe's DEPTH-stage shadow shift register with completion write and flush masking.
// Latency: issue lands in stage 1 on the next edge; entries advance one stage per cycle; retire view is combinational.
// Backpressure: none; the lane never stalls.
// Ports: iss_* load stage 1; res_* complete the entry at res_stage; flush/flush_stage kill entries;
//        st_* expose every stage for forwarding; ret_* describe the stage-DEPTH entry leaving on the next edge.
module spu_fwd_lane
  import spu_fwd_pipeline_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int DATA_WD = DEF_DATA_WD,
  // Set for every pipe except pipe 0: such a pipe is younger than the branch at flush_stage.
  parameter bit YOUNGER = 1'b0,
  localparam int SW     = stage_wd(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic                     iss_wr_en,
  input  logic [ADDR_WD-1:0]       iss_rt_addr,
  input  logic                     res_valid,
  input  logic [SW-1:0]            res_stage,
  input  logic [DATA_WD-1:0]       res_data,
  input  logic                     flush,
  input  logic [SW-1:0]            flush_stage,
  output logic [DEPTH-1:0]         st_valid,
  output logic [DEPTH-1:0]         st_ready,
  output logic [DEPTH*ADDR_WD-1:0] st_addr,
  output logic [DEPTH*DATA_WD-1:0] st_data,
  output logic                     ret_valid,
  output logic                     ret_ready,
  output logic [ADDR_WD-1:0]       ret_addr,
  output logic [DATA_WD-1:0]       ret_data
);

  // Index k holds stage k+1.
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   ready_q;
  logic [ADDR_WD-1:0] addr_q [DEPTH];
  logic [DATA_WD-1:0] data_q [DEPTH];

  logic [DEPTH-1:0]   live;  // valid and not killed by this cycle's flush
  logic [DEPTH-1:0]   cmp;   // completion lands on this entry

  always_comb begin
    live = '0;
    cmp  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      live[k] = valid_q[k] &&
                !(flush && ((SW'(k + 1) < flush_stage) ||
                            (YOUNGER && (SW'(k + 1) == flush_stage))));
      // Gated by live so that a flush beats a completion on the same entry.
      cmp[k]  = live[k] && res_valid && (res_stage == SW'(k + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= iss_valid && iss_wr_en && !flush;
      ready_q[0] <= 1'b0;
      addr_q[0]  <= iss_rt_addr;
      data_q[0]  <= '0;
      // A completion is written into the entry's next position as it shifts.
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= live[k-1];
        ready_q[k] <= ready_q[k-1] || cmp[k-1];
        addr_q[k]  <= addr_q[k-1];
        data_q[k]  <= cmp[k-1] ? res_data : data_q[k-1];
      end
    end
  end

  // A completion at stage DEPTH goes straight to the writeback registers.
  assign ret_valid = live[DEPTH-1];
  assign ret_ready = ready_q[DEPTH-1] || cmp[DEPTH-1];
  assign ret_addr  = addr_q[DEPTH-1];
  assign ret_data  = cmp[DEPTH-1] ? res_data : data_q[DEPTH-1];

  assign st_valid = valid_q;
  assign st_ready = ready_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign st_addr[k*ADDR_WD +: ADDR_WD] = addr_q[k];
    assign st_data[k*DATA_WD +: DATA_WD] = data_q[k];
  end

endmodule

// File: rtl/spu_fwd_pipeline.sv
// Purpose: result tracking and operand forwarding for NUM_PIPES SPU issue pipes, with RAW stall detect and writeback.
// Latency: fw_data/rd_stall combinational from stage state; wb_* registered one cycle after an entry sits in stage DEPTH.
// Backpressure: none inside the block; rd_stall tells issue logic to hold a dependent read.
// Ports: iss_* issue per pipe; res_* completions per pipe; flush/flush_stage kill younger work;
//        rd_addr/rd_rf_data read ports with fw_data/rd_stall results; wb_* register-file writes; err_unready sticky error.
module spu_fwd_pipeline
  import spu_fwd_pipeline_pkg::*;
#(
  parameter int NUM_PIPES = DEF_NUM_PIPES,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int DATA_WD   = DEF_DATA_WD,
  parameter int ADDR_WD   = DEF_ADDR_WD,
  localparam int SW       = stage_wd(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PIPES-1:0]                iss_valid,
  input  logic [NUM_PIPES-1:0]                iss_wr_en,
  input  logic [NUM_PIPES*ADDR_WD-1:0]        iss_rt_addr,
  input  logic [NUM_PIPES-1:0]                res_valid,
  input  logic [NUM_PIPES*SW-1:0]             res_stage,
  input  logic [NUM_PIPES*DATA_WD-1:0]        res_data,
  input  logic                                flush,
  input  logic [SW-1:0]                       flush_stage,
  input  logic [NUM_PIPES*NUM_RD*ADDR_WD-1:0] rd_addr,
  input  logic [NUM_PIPES*NUM_RD*DATA_WD-1:0] rd_rf_data,
  output logic [NUM_PIPES*NUM_RD*DATA_WD-1:0] fw_data,
  output logic [NUM_PIPES-1:0]                rd_stall,
  output logic [NUM_PIPES-1:0]                wb_en,
  output logic [NUM_PIPES*ADDR_WD-1:0]        wb_addr,
  output logic [NUM_PIPES*DATA_WD-1:0]        wb_data,
  output logic                                err_unready
);

  logic [DEPTH-1:0]         st_valid [NUM_PIPES];
  logic [DEPTH-1:0]         st_ready [NUM_PIPES];
  logic [DEPTH*ADDR_WD-1:0] st_addr  [NUM_PIPES];
  logic [DEPTH*DATA_WD-1:0] st_data  [NUM_PIPES];
  logic [NUM_PIPES-1:0]     ret_valid;
  logic [NUM_PIPES-1:0]     ret_ready;
  logic [ADDR_WD-1:0]       ret_addr [NUM_PIPES];
  logic [DATA_WD-1:0]       ret_data [NUM_PIPES];

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_lane
    spu_fwd_lane #(
      .DEPTH   (DEPTH),
      .ADDR_WD (ADDR_WD),
      .DATA_WD (DATA_WD),
      .YOUNGER (p > 0)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .iss_valid   (iss_valid[p]),
      .iss_wr_en   (iss_wr_en[p]),
      .iss_rt_addr (iss_rt_addr[p*ADDR_WD +: ADDR_WD]),
      .res_valid   (res_valid[p]),
      .res_stage   (res_stage[p*SW +: SW]),
      .res_data    (res_data[p*DATA_WD +: DATA_WD]),
      .flush       (flush),
      .flush_stage (flush_stage),
      .st_valid    (st_valid[p]),
      .st_ready    (st_ready[p]),
      .st_addr     (st_addr[p]),
      .st_data     (st_data[p]),
      .ret_valid   (ret_valid[p]),
      .ret_ready   (ret_ready[p]),
      .ret_addr    (ret_addr[p]),
      .ret_data    (ret_data[p])
    );
  end

  // Priority select: scan oldest stage first and lower pipe first, so the last
  // match seen is the youngest (lowest stage, then highest pipe index).
  logic               hit;
  logic               hit_rdy;
  logic [DATA_WD-1:0] hit_dat;

  always_comb begin
    fw_data  = rd_rf_data;
    rd_stall = '0;
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_dat  = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      for (int r = 0; r < NUM_RD; r++) begin
        hit     = 1'b0;
        hit_rdy = 1'b0;
        hit_dat = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
          for (int q = 0; q < NUM_PIPES; q++) begin
            if (st_valid[q][s] &&
                (st_addr[q][s*ADDR_WD +: ADDR_WD] == rd_addr[(p*NUM_RD + r)*ADDR_WD +: ADDR_WD])) begin
              hit     = 1'b1;
              hit_rdy = st_ready[q][s];
              hit_dat = st_data[q][s*DATA_WD +: DATA_WD];
            end
          end
        end
        // An unready winner shadows any older ready copy: stall and fall back to the RF value.
        if (hit && hit_rdy) begin
          fw_data[(p*NUM_RD + r)*DATA_WD +: DATA_WD] = hit_dat;
        end
        if (hit && !hit_rdy) begin
          rd_stall[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en       <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      err_unready <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        wb_en[p] <= ret_valid[p] && ret_ready[p];
        if (ret_valid[p] && ret_ready[p]) begin
          wb_addr[p*ADDR_WD +: ADDR_WD] <= ret_addr[p];
          wb_data[p*DATA_WD +: DATA_WD] <= ret_data[p];
        end
      end
      if (|(ret_valid & ~ret_ready)) begin
        err_unready <= 1'b1;
      end
    end
  end

endmodule
